// File: rtl/axi_mem_arbiter_if.sv
// Client request/response bundle and AXI4 master channels for axi_mem_arbiter.
// The master modport is the arbiter's side; slave is the clients plus the AXI slave.
interface axi_mem_arbiter_if #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic [NUM_M-1:0]          req_valid_i;
   logic [NUM_M-1:0]          req_ready_o;
   logic [NUM_M-1:0]          req_wen_i;
   logic [NUM_M*ADDR_W-1:0]   req_addr_i;
   logic [NUM_M*3-1:0]        req_size_i;
   logic [NUM_M*DATA_W-1:0]   req_wdata_i;
   logic [NUM_M*DATA_W/8-1:0] req_wstrb_i;
   logic [NUM_M-1:0]          rsp_valid_o;
   logic [DATA_W-1:0]         rsp_rdata_o;
   logic                      rsp_err_o;

   logic                      io_master_awvalid;
   logic                      io_master_awready;
   logic [ADDR_W-1:0]         io_master_awaddr;
   logic [ID_W-1:0]           io_master_awid;
   logic [7:0]                io_master_awlen;
   logic [2:0]                io_master_awsize;
   logic [1:0]                io_master_awburst;

   logic                      io_master_wvalid;
   logic                      io_master_wready;
   logic [DATA_W-1:0]         io_master_wdata;
   logic [DATA_W/8-1:0]       io_master_wstrb;
   logic                      io_master_wlast;

   logic                      io_master_bvalid;
   logic                      io_master_bready;
   logic [1:0]                io_master_bresp;
   logic [ID_W-1:0]           io_master_bid;

   logic                      io_master_arvalid;
   logic                      io_master_arready;
   logic [ADDR_W-1:0]         io_master_araddr;
   logic [ID_W-1:0]           io_master_arid;
   logic [7:0]                io_master_arlen;
   logic [2:0]                io_master_arsize;
   logic [1:0]                io_master_arburst;

   logic                      io_master_rvalid;
   logic                      io_master_rready;
   logic [DATA_W-1:0]         io_master_rdata;
   logic [1:0]                io_master_rresp;
   logic                      io_master_rlast;
   logic [ID_W-1:0]           io_master_rid;

   modport master (
      input  req_valid_i, req_wen_i, req_addr_i, req_size_i, req_wdata_i, req_wstrb_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
             io_master_awsize, io_master_awburst,
      input  io_master_awready,
      output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
      input  io_master_wready,
      input  io_master_bvalid, io_master_bresp, io_master_bid,
      output io_master_bready,
      output io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
             io_master_arsize, io_master_arburst,
      input  io_master_arready,
      input  io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid,
      output io_master_rready
   );

   modport slave (
      output req_valid_i, req_wen_i, req_addr_i, req_size_i, req_wdata_i, req_wstrb_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  io_master_awvalid, io_master_awaddr, io_master_awid, io_master_awlen,
             io_master_awsize, io_master_awburst,
      output io_master_awready,
      input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
      output io_master_wready,
      output io_master_bvalid, io_master_bresp, io_master_bid,
      input  io_master_bready,
      input  io_master_arvalid, io_master_araddr, io_master_arid, io_master_arlen,
             io_master_arsize, io_master_arburst,
      output io_master_arready,
      output io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid,
      input  io_master_rready
   );
endinterface

// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter folding NUM_M single-beat memory clients onto one AXI4 master port,
// one outstanding transaction at a time; the AXI ID carries the granted client index.
module axi_mem_arbiter #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input logic               clk_i,
   input logic               rst_i,
   axi_mem_arbiter_if.master bus
);
   localparam int GW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int GW1 = GW + 1;
   localparam int SW  = DATA_W / 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW_W,
      S_B,
      S_RSP
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [GW-1:0]     rr_q;
   logic [GW-1:0]     g_q;
   logic [GW-1:0]     gnt_idx;
   logic              gnt_found;
   logic [GW1-1:0]    scan;
   logic              accept;
   logic              aw_done_q;
   logic              w_done_q;
   logic              aw_hs;
   logic              w_hs;
   logic              r_last_hs;
   logic              b_hs;
   logic [ID_W-1:0]   g_id;

   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        size_q;
   logic [DATA_W-1:0] wdata_q;
   logic [SW-1:0]     wstrb_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   // First valid client at or after the rr pointer, wrapping NUM_M-1 -> 0.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan      = '0;
      for (int i = 0; i < NUM_M; i++) begin
         scan = {1'b0, rr_q} + GW1'(i);
         if (scan >= GW1'(NUM_M)) begin
            scan = scan - GW1'(NUM_M);
         end
         if (!gnt_found && bus.req_valid_i[scan[GW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan[GW-1:0];
         end
      end
   end

   assign accept    = (state_q == S_IDLE) && gnt_found;
   assign aw_hs     = (state_q == S_AW_W) && !aw_done_q && bus.io_master_awready;
   assign w_hs      = (state_q == S_AW_W) && !w_done_q && bus.io_master_wready;
   assign r_last_hs = (state_q == S_R) && bus.io_master_rvalid && bus.io_master_rlast;
   assign b_hs      = (state_q == S_B) && bus.io_master_bvalid;
   assign g_id      = ID_W'(g_q);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               state_d = bus.req_wen_i[gnt_idx] ? S_AW_W : S_AR;
            end
         end
         S_AR: begin
            if (bus.io_master_arready) begin
               state_d = S_R;
            end
         end
         S_R: begin
            if (r_last_hs) begin
               state_d = S_RSP;
            end
         end
         // The two channels may complete in either order or together.
         S_AW_W: begin
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               state_d = S_B;
            end
         end
         S_B: begin
            if (b_hs) begin
               state_d = S_RSP;
            end
         end
         S_RSP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready_o       = '0;
      bus.rsp_valid_o       = '0;
      bus.io_master_arvalid = 1'b0;
      bus.io_master_rready  = 1'b0;
      bus.io_master_awvalid = 1'b0;
      bus.io_master_wvalid  = 1'b0;
      bus.io_master_bready  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               bus.req_ready_o = NUM_M'(1) << gnt_idx;
            end
         end
         S_AR:   bus.io_master_arvalid = 1'b1;
         S_R:    bus.io_master_rready  = 1'b1;
         S_AW_W: begin
            bus.io_master_awvalid = !aw_done_q;
            bus.io_master_wvalid  = !w_done_q;
         end
         S_B:    bus.io_master_bready  = 1'b1;
         S_RSP:  bus.rsp_valid_o       = NUM_M'(1) << g_q;
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rr_q      <= '0;
         g_q       <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         if (accept) begin
            g_q       <= gnt_idx;
            rr_q      <= (gnt_idx == GW'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end
         if (aw_hs) begin
            aw_done_q <= 1'b1;
         end
         if (w_hs) begin
            w_done_q <= 1'b1;
         end
         // A response whose ID does not name the granted client is reported as an error.
         if (r_last_hs) begin
            rdata_q <= bus.io_master_rdata;
            err_q   <= (bus.io_master_rresp != 2'b00) || (bus.io_master_rid != g_id);
         end
         if (b_hs) begin
            rdata_q <= '0;
            err_q   <= (bus.io_master_bresp != 2'b00) || (bus.io_master_bid != g_id);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept) begin
         addr_q  <= bus.req_addr_i[32'(gnt_idx) * ADDR_W +: ADDR_W];
         size_q  <= bus.req_size_i[32'(gnt_idx) * 3 +: 3];
         wdata_q <= bus.req_wdata_i[32'(gnt_idx) * DATA_W +: DATA_W];
         wstrb_q <= bus.req_wstrb_i[32'(gnt_idx) * SW +: SW];
      end
   end

   assign bus.io_master_araddr  = addr_q;
   assign bus.io_master_arid    = g_id;
   assign bus.io_master_arlen   = 8'd0;
   assign bus.io_master_arsize  = size_q;
   assign bus.io_master_arburst = 2'b01;

   assign bus.io_master_awaddr  = addr_q;
   assign bus.io_master_awid    = g_id;
   assign bus.io_master_awlen   = 8'd0;
   assign bus.io_master_awsize  = size_q;
   assign bus.io_master_awburst = 2'b01;

   assign bus.io_master_wdata   = wdata_q;
   assign bus.io_master_wstrb   = wstrb_q;
   assign bus.io_master_wlast   = 1'b1;

   assign bus.rsp_rdata_o       = rdata_q;
   assign bus.rsp_err_o         = err_q;
endmodule
